cook_cycle_controller: RTL and testbench
========================================

Name:
cook_cycle_controller

Overview:
- Top-level cook sequencer for the microwave. Owns the countdown timer and the cook state machine.
- Drives the magnetron enable with power-level duty cycling, and gates it with the door interlock and the stop/clear buttons.
- Sits between the debounced front-panel buttons, the 1 Hz timebase and the magnetron driver. Also feeds the display (BCD time) and the buzzer/lamp.

Parameters:
- DUTY_PERIOD, default 10: length of the power-modulation window, in seconds (ticks).
- MAX_POWER, default 10: highest power level. Equal to DUTY_PERIOD (full-on).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick_1hz  in  1  one-clk-wide pulse, once per second
- startn  in  1  start button, active-low, debounced level
- stopn  in  1  pause button, active-low, debounced level
- clearn  in  1  clear button, active-low, debounced level
- door_closed  in  1  1 = door closed
- time_load_en  in  1  load time_min_in/time_sec_in (honoured in IDLE only)
- time_min_in  in  8  preset minutes, BCD 00..99
- time_sec_in  in  8  preset seconds, BCD 00..59
- power_level  in  4  1..MAX_POWER; 0 or >MAX_POWER treated as MAX_POWER
- mag_on  out  1  magnetron enable
- time_min  out  8  remaining minutes, BCD
- time_sec  out  8  remaining seconds, BCD
- state  out  2  00 IDLE, 01 COOK, 10 PAUSE, 11 DONE
- done_beep  out  1  buzzer enable
- lamp_on  out  1  cavity lamp

Behaviour:
Reset (async, immediate):
- state=IDLE, time=00:00, phase=0.
- mag_req=0, done_beep=0, beep_cnt=0, startn_q=1.

Start edge:
- start_evt = startn_q & ~startn, where startn_q is startn registered.
- Holding start produces only one event.

Transitions are evaluated per clk. Priority, highest first:
- clearn=0: from any state go to IDLE, time=00:00, phase=0, done_beep=0. Wins over tick, start and load in the same cycle.
- COOK:
  - door_closed=0 or stopn=0: go to PAUSE. Time and phase are held.
  - Otherwise, on tick_1hz: decrement time and advance phase (wraps DUTY_PERIOD-1 -> 0).
  - If the decrement reaches 00:00: go to DONE.
- PAUSE:
  - start_evt & door_closed & stopn: go to COOK. Resumes the remaining time and the held phase.
  - Otherwise stay.
- IDLE:
  - time_load_en: load the preset. The load is ignored if any nibble is >9 or the seconds tens digit is >5.
  - start_evt & door_closed & stopn & time!=00:00: go to COOK with phase=0.
  - start_evt with time 00:00: ignored.
- DONE:
  - done_beep=1 for 3 ticks (beep_cnt), then 0.
  - Opening the door or clearn=0: go to IDLE.
  - start_evt: ignored.

Countdown rules:
- BCD decrement: sec units borrow from sec tens.
- xx:00 -> (xx-1):59.
- Minutes 00..99.
- Decrement happens only on a tick while already in COOK. A tick in the entry cycle is not counted.

Simultaneous events:
- start_evt and stopn=0 in the same cycle: stop wins.
- tick and a pause condition in the same cycle: pause wins, no decrement.

Magnetron enable:
- mag_req (registered) = 1 in COOK when phase < power_eff.
- mag_on = mag_req & door_closed & stopn & clearn. The combinational gating guarantees the magnetron is off in the same cycle as a door-open, stop or clear.

Other outputs:
- lamp_on = ~door_closed | (state==COOK).
- time_min, time_sec and state are direct register outputs, 0-cycle latency.

Test Plan:
1. Load 00:05, power 10, door closed, pulse startn low. Expect:
   - COOK next clk, mag_on=1 continuously.
   - After 5 ticks: time 00:00, state=DONE, mag_on=0.
   - done_beep high for exactly 3 ticks.
2. Load 01:00, power 3, start, run 20 ticks. Expect:
   - mag_on high on ticks 0-2 and 10-12 of each window.
   - time steps 01:00 -> 00:59 on the first tick, ends at 00:40.
3. Load 00:30, cook 4 ticks, deassert door_closed. Expect:
   - mag_on=0 in the same cycle, PAUSE next clk, time 00:26 held.
   - Close the door and press start: COOK resumes, reaches DONE after 26 more ticks.
4. During COOK, assert clearn low in the same cycle as tick_1hz and start_evt. Expect:
   - IDLE, time 00:00, mag_on=0, no decrement.
5. In IDLE:
   - Load time_sec_in=8'h75: load ignored, time unchanged.
   - Press start with 00:00: stays IDLE.
   - Hold startn low across a load then a release/press: only the new falling edge starts.
6. Assert rst asynchronously mid-COOK at 00:12 with mag_on=1. Expect:
   - mag_on=0, state=IDLE and time=00:00 immediately, without waiting for clk.

Source files
------------

// File: rtl/cook_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cook_cycle_controller
//  Purpose  : Microwave cook sequencer. Owns the BCD countdown timer and the
//             IDLE/COOK/PAUSE/DONE state machine, duty-cycles the magnetron
//             according to the power level and gates it with the door
//             interlock and the stop/clear buttons.
//  Ports    :
//    clk, rst         system clock, asynchronous active-high reset
//    tick_1hz         one-clk pulse per second (countdown / duty timebase)
//    startn/stopn/    debounced active-low front-panel buttons
//    clearn
//    door_closed      1 = door closed (interlock)
//    time_load_en     load time_min_in/time_sec_in (IDLE only, BCD checked)
//    time_min_in/sec  preset time, BCD
//    power_level      1..MAX_POWER; 0 or out-of-range means full power
//    mag_on           magnetron enable (registered request, live gating)
//    time_min/sec     remaining time, BCD
//    state            00 IDLE, 01 COOK, 10 PAUSE, 11 DONE
//    done_beep        buzzer enable, three seconds after completion
//    lamp_on          cavity lamp
//  Revision : 1.0  initial release
// ============================================================================
module cook_cycle_controller #(
   parameter int DUTY_PERIOD = 10,
   parameter int MAX_POWER   = DUTY_PERIOD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   input  logic       door_closed,
   input  logic       time_load_en,
   input  logic [7:0] time_min_in,
   input  logic [7:0] time_sec_in,
   input  logic [3:0] power_level,
   output logic       mag_on,
   output logic [7:0] time_min,
   output logic [7:0] time_sec,
   output logic [1:0] state,
   output logic       done_beep,
   output logic       lamp_on
);

   localparam int              PH_W         = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
   localparam logic [PH_W-1:0] c_phase_last = PH_W'(DUTY_PERIOD - 1);
   localparam logic [3:0]      c_max_power  = 4'(MAX_POWER);
   localparam logic [1:0]      c_beep_last  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COOK  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t          r_state;
   logic [7:0]      r_min;
   logic [7:0]      r_sec;
   logic [PH_W-1:0] r_phase;
   logic            r_mag_req;
   logic            r_done_beep;
   logic [1:0]      r_beep_cnt;
   logic            r_startn_q;

   // Next-state values
   state_t          w_state_nx;
   logic [7:0]      w_min_nx;
   logic [7:0]      w_sec_nx;
   logic [PH_W-1:0] w_phase_nx;
   logic            w_mag_nx;
   logic            w_beep_nx;
   logic [1:0]      w_beep_cnt_nx;

   // Helpers
   logic            w_start_evt;
   logic            w_run_ok;
   logic            w_time_zero;
   logic            w_load_ok;
   logic [3:0]      w_power_eff;
   logic [7:0]      w_dec_min;
   logic [7:0]      w_dec_sec;
   logic            w_dec_zero;
   logic [PH_W-1:0] w_phase_inc;

   // A held start button yields a single event on its falling edge.
   assign w_start_evt = r_startn_q & ~startn;
   assign w_run_ok    = door_closed & stopn;
   assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);

   // Reject presets that are not valid BCD minutes 00..99 / seconds 00..59.
   assign w_load_ok = (time_min_in[7:4] <= 4'd9) && (time_min_in[3:0] <= 4'd9) &&
                      (time_sec_in[7:4] <= 4'd5) && (time_sec_in[3:0] <= 4'd9);

   // Out-of-range power requests fall back to full power.
   assign w_power_eff = ((power_level == 4'd0) || (power_level > c_max_power)) ?
                        c_max_power : power_level;

   assign w_phase_inc = (r_phase == c_phase_last) ? '0 : r_phase + PH_W'(1);

   // ------------------------------------------------------------------
   // BCD one-second decrement of the remaining time
   // ------------------------------------------------------------------
   always_comb begin
      w_dec_min = r_min;
      w_dec_sec = r_sec;
      if (r_sec[3:0] != 4'd0) begin
         w_dec_sec = {r_sec[7:4], r_sec[3:0] - 4'd1};
      end else if (r_sec[7:4] != 4'd0) begin
         w_dec_sec = {r_sec[7:4] - 4'd1, 4'd9};
      end else if (r_min != 8'h00) begin
         // xx:00 borrows a minute and rolls the seconds to 59
         w_dec_sec = 8'h59;
         if (r_min[3:0] != 4'd0) begin
            w_dec_min = {r_min[7:4], r_min[3:0] - 4'd1};
         end else begin
            w_dec_min = {r_min[7:4] - 4'd1, 4'd9};
         end
      end
   end

   assign w_dec_zero = (w_dec_min == 8'h00) && (w_dec_sec == 8'h00);

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nx    = r_state;
      w_min_nx      = r_min;
      w_sec_nx      = r_sec;
      w_phase_nx    = r_phase;
      w_beep_nx     = r_done_beep;
      w_beep_cnt_nx = r_beep_cnt;
      w_mag_nx      = 1'b0;

      if (!clearn) begin
         // Clear overrides every other event in the same cycle.
         w_state_nx    = ST_IDLE;
         w_min_nx      = 8'h00;
         w_sec_nx      = 8'h00;
         w_phase_nx    = '0;
         w_beep_nx     = 1'b0;
         w_beep_cnt_nx = 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_evt && w_run_ok && !w_time_zero) begin
                  w_state_nx = ST_COOK;
                  w_phase_nx = '0;
               end else if (time_load_en && w_load_ok) begin
                  w_min_nx = time_min_in;
                  w_sec_nx = time_sec_in;
               end
            end

            ST_COOK: begin
               // Pause beats a coincident tick: nothing is counted.
               if (!w_run_ok) begin
                  w_state_nx = ST_PAUSE;
               end else if (tick_1hz) begin
                  w_min_nx   = w_dec_min;
                  w_sec_nx   = w_dec_sec;
                  w_phase_nx = w_phase_inc;
                  if (w_dec_zero) begin
                     w_state_nx    = ST_DONE;
                     w_beep_nx     = 1'b1;
                     w_beep_cnt_nx = 2'd0;
                  end
               end
            end

            ST_PAUSE: begin
               if (w_start_evt && w_run_ok) begin
                  w_state_nx = ST_COOK;
               end
            end

            ST_DONE: begin
               if (!door_closed) begin
                  w_state_nx    = ST_IDLE;
                  w_beep_nx     = 1'b0;
                  w_beep_cnt_nx = 2'd0;
               end else if (tick_1hz && r_done_beep) begin
                  // Buzzer stays on through the third tick after completion.
                  w_beep_cnt_nx = r_beep_cnt + 2'd1;
                  if (r_beep_cnt == c_beep_last) begin
                     w_beep_nx = 1'b0;
                  end
               end
            end

            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end

      // Request is formed from the next state/phase so it lines up with the
      // cycle in which the state register actually shows COOK.
      w_mag_nx = (w_state_nx == ST_COOK) && (8'(w_phase_nx) < 8'(w_power_eff));
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_min       <= 8'h00;
         r_sec       <= 8'h00;
         r_phase     <= '0;
         r_mag_req   <= 1'b0;
         r_done_beep <= 1'b0;
         r_beep_cnt  <= 2'd0;
         r_startn_q  <= 1'b1;
      end else begin
         r_state     <= w_state_nx;
         r_min       <= w_min_nx;
         r_sec       <= w_sec_nx;
         r_phase     <= w_phase_nx;
         r_mag_req   <= w_mag_nx;
         r_done_beep <= w_beep_nx;
         r_beep_cnt  <= w_beep_cnt_nx;
         r_startn_q  <= startn;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Live gating switches the magnetron off in the very cycle the door
   // opens or stop/clear is pressed, ahead of the registered request.
   assign mag_on    = r_mag_req & door_closed & stopn & clearn;
   assign time_min  = r_min;
   assign time_sec  = r_sec;
   assign state     = r_state;
   assign done_beep = r_done_beep;
   assign lamp_on   = ~door_closed | (r_state == ST_COOK);

endmodule
`default_nettype wire

// File: tb/tb_cook_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cook_cycle_controller
//  Purpose  : Self-checking bench for cook_cycle_controller. A reference
//             model tracks remaining time as plain integer seconds and is
//             stepped once per clock alongside directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cook_cycle_controller;

   localparam int DUTY = 10;
   localparam int MAXP = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       startn;
   logic       stopn;
   logic       clearn;
   logic       door_closed;
   logic       time_load_en;
   logic [7:0] time_min_in;
   logic [7:0] time_sec_in;
   logic [3:0] power_level;
   logic       mag_on;
   logic [7:0] time_min;
   logic [7:0] time_sec;
   logic [1:0] state;
   logic       done_beep;
   logic       lamp_on;

   cook_cycle_controller #(.DUTY_PERIOD(DUTY), .MAX_POWER(MAXP)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .tick_1hz     (tick_1hz),
      .startn       (startn),
      .stopn        (stopn),
      .clearn       (clearn),
      .door_closed  (door_closed),
      .time_load_en (time_load_en),
      .time_min_in  (time_min_in),
      .time_sec_in  (time_sec_in),
      .power_level  (power_level),
      .mag_on       (mag_on),
      .time_min     (time_min),
      .time_sec     (time_sec),
      .state        (state),
      .done_beep    (done_beep),
      .lamp_on      (lamp_on)
   );

   always #5 clk = ~clk;

   // Reference model: 0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
   int m_state;
   int m_secs;
   int m_phase;
   int m_beep_left;
   bit m_mag;
   bit m_beep;
   bit m_startn_q;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int power_eff(input logic [3:0] p);
      if (p == 4'd0 || int'(p) > MAXP) return MAXP;
      return int'(p);
   endfunction

   task automatic model_reset();
      m_state = 0; m_secs = 0; m_phase = 0; m_beep_left = 0;
      m_mag = 1'b0; m_beep = 1'b0; m_startn_q = 1'b1;
   endtask

   task automatic model_step();
      bit start_evt;
      bit run_ok;
      int mt, mu, st, su;
      start_evt = m_startn_q && !startn;
      run_ok    = door_closed && stopn;
      mt = int'(time_min_in[7:4]); mu = int'(time_min_in[3:0]);
      st = int'(time_sec_in[7:4]); su = int'(time_sec_in[3:0]);
      if (!clearn) begin
         m_state = 0; m_secs = 0; m_phase = 0; m_beep = 0; m_beep_left = 0;
      end else begin
         case (m_state)
            0: begin
               if (start_evt && run_ok && m_secs != 0) begin
                  m_state = 1; m_phase = 0;
               end else if (time_load_en && mt <= 9 && mu <= 9 && st <= 5 && su <= 9) begin
                  m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
               end
            end
            1: begin
               if (!run_ok) m_state = 2;
               else if (tick_1hz) begin
                  m_secs  = m_secs - 1;
                  m_phase = (m_phase + 1) % DUTY;
                  if (m_secs == 0) begin
                     m_state = 3; m_beep = 1; m_beep_left = 3;
                  end
               end
            end
            2: begin
               if (start_evt && run_ok) m_state = 1;
            end
            default: begin
               if (!door_closed) begin
                  m_state = 0; m_beep = 0; m_beep_left = 0;
               end else if (tick_1hz && m_beep) begin
                  m_beep_left = m_beep_left - 1;
                  if (m_beep_left == 0) m_beep = 0;
               end
            end
         endcase
      end
      m_mag      = (m_state == 1) && (m_phase < power_eff(power_level));
      m_startn_q = startn;
   endtask

   task automatic check_comb(input string where);
      bit exp_mag;
      exp_mag = m_mag && door_closed && stopn && clearn;
      chk({where, "_mag_on"}, 32'(mag_on), 32'(exp_mag));
      chk({where, "_lamp"}, 32'(lamp_on), 32'(!door_closed || m_state == 1));
   endtask

   task automatic check_regs(input string where);
      chk({where, "_state"}, 32'(state), 32'(m_state));
      chk({where, "_min"}, 32'(time_min), 32'(to_bcd(m_secs / 60)));
      chk({where, "_sec"}, 32'(time_sec), 32'(to_bcd(m_secs % 60)));
      chk({where, "_beep"}, 32'(done_beep), 32'(m_beep));
      check_comb(where);
   endtask

   // Inputs change at posedge+1; gating is checked before the edge, the
   // registered outputs just after it.
   task automatic cycle();
      #1;
      check_comb("pre");
      model_step();
      @(posedge clk);
      #1;
      check_regs("post");
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_tick();
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      run(2);
   endtask

   task automatic press_start();
      startn = 1'b0;
      cycle();
      startn = 1'b1;
      cycle();
   endtask

   task automatic load(input logic [7:0] mn, input logic [7:0] sc);
      time_load_en = 1'b1;
      time_min_in  = mn;
      time_sec_in  = sc;
      cycle();
      time_load_en = 1'b0;
      cycle();
   endtask

   task automatic do_clear();
      clearn = 1'b0;
      cycle();
      clearn = 1'b1;
      cycle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tick_1hz = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      door_closed = 1'b1; time_load_en = 1'b0; time_min_in = 8'h00;
      time_sec_in = 8'h00; power_level = 4'd10;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_time", 32'({time_min, time_sec}), 32'h0000);
      chk("rst_mag", 32'(mag_on), 32'd0);
      chk("rst_beep", 32'(done_beep), 32'd0);
      rst = 1'b0;
      cycle();

      // 1: 00:05 at full power, then the three-second buzzer
      load(8'h00, 8'h05);
      startn = 1'b0;
      cycle();
      chk("t1_cook", 32'(state), 32'd1);
      chk("t1_mag", 32'(mag_on), 32'd1);
      startn = 1'b1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         do_tick();
         chk("t1_mag_run", 32'(mag_on), 32'(i < 4));
      end
      chk("t1_done", 32'(state), 32'd3);
      chk("t1_zero", 32'({time_min, time_sec}), 32'h0000);
      chk("t1_beep0", 32'(done_beep), 32'd1);
      for (int i = 0; i < 3; i++) begin
         do_tick();
         chk("t1_beep", 32'(done_beep), 32'(i < 2));
      end
      door_closed = 1'b0;
      cycle();
      door_closed = 1'b1;
      cycle();
      chk("t1_idle", 32'(state), 32'd0);

      // 2: 01:00 at power 3 for 20 seconds
      power_level = 4'd3;
      load(8'h01, 8'h00);
      press_start();
      chk("t2_mag_first", 32'(mag_on), 32'd1);
      for (int i = 0; i < 20; i++) begin
         do_tick();
         chk("t2_mag", 32'(mag_on), 32'(((i + 1) % 10) < 3));
         if (i == 0) chk("t2_first", 32'({time_min, time_sec}), 32'h0059);
      end
      chk("t2_end", 32'({time_min, time_sec}), 32'h0040);
      do_clear();

      // 3: door opened mid-cook, then resumed
      power_level = 4'd10;
      load(8'h00, 8'h30);
      press_start();
      for (int i = 0; i < 4; i++) do_tick();
      chk("t3_26", 32'(time_sec), 32'h26);
      door_closed = 1'b0;
      #1;
      chk("t3_mag_gate", 32'(mag_on), 32'd0);
      cycle();
      chk("t3_pause", 32'(state), 32'd2);
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      run(2);
      chk("t3_held", 32'(time_sec), 32'h26);
      door_closed = 1'b1;
      cycle();
      press_start();
      chk("t3_resume", 32'(state), 32'd1);
      for (int i = 0; i < 26; i++) do_tick();
      chk("t3_done", 32'(state), 32'd3);
      door_closed = 1'b0;
      cycle();
      door_closed = 1'b1;
      cycle();

      // 4: clear coincident with tick and start edge
      load(8'h00, 8'h20);
      press_start();
      do_tick();
      do_tick();
      clearn = 1'b0; tick_1hz = 1'b1; startn = 1'b0;
      cycle();
      chk("t4_state", 32'(state), 32'd0);
      chk("t4_time", 32'({time_min, time_sec}), 32'h0000);
      chk("t4_mag", 32'(mag_on), 32'd0);
      clearn = 1'b1; tick_1hz = 1'b0; startn = 1'b1;
      cycle();

      // 5: idle-only behaviour
      load(8'h00, 8'h75);
      chk("t5_bad_load", 32'({time_min, time_sec}), 32'h0000);
      press_start();
      chk("t5_start_zero", 32'(state), 32'd0);
      startn = 1'b0;
      cycle();
      load(8'h00, 8'h10);
      run(2);
      chk("t5_held", 32'(state), 32'd0);
      startn = 1'b1;
      cycle();
      chk("t5_release", 32'(state), 32'd0);
      startn = 1'b0;
      cycle();
      chk("t5_new_edge", 32'(state), 32'd1);
      startn = 1'b1;
      cycle();
      do_clear();
      load(8'h00, 8'h07);
      load(8'h00, 8'h75);
      chk("t5_keep1", 32'({time_min, time_sec}), 32'h0007);
      load(8'hA1, 8'h05);
      chk("t5_keep2", 32'({time_min, time_sec}), 32'h0007);
      load(8'h00, 8'h5C);
      chk("t5_keep3", 32'({time_min, time_sec}), 32'h0007);
      do_clear();

      // 6: asynchronous reset mid-cook
      load(8'h00, 8'h15);
      press_start();
      for (int i = 0; i < 3; i++) do_tick();
      chk("t6_pre_time", 32'(time_sec), 32'h12);
      chk("t6_pre_mag", 32'(mag_on), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_state", 32'(state), 32'd0);
      chk("t6_time", 32'({time_min, time_sec}), 32'h0000);
      chk("t6_mag", 32'(mag_on), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_regs("t6_after");

      // Random stress against the model
      for (int i = 0; i < 4000; i++) begin
         tick_1hz = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) startn = ~startn;
         stopn  = ($urandom_range(0, 19) != 0);
         clearn = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
         time_load_en = ($urandom_range(0, 11) == 0);
         if (time_load_en) begin
            time_min_in = {4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : 0),
                           4'($urandom_range(0, 1))};
            time_sec_in = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
         end
         if ($urandom_range(0, 63) == 0) power_level = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
